// File: rtl/carregador_programa_pkg.sv
// rtl/carregador_programa_pkg.sv - shared encodings and sizes for the program loader
package carregador_programa_pkg;
   localparam int MEM_PROFUNDIDADE = 256;
   localparam int LARGURA          = 8;
   localparam int ENDERECO         = 8;

   typedef enum logic [2:0] {
      ESPERA_TAM = 3'd0,
      CARGA      = 3'd1,
      CHECK      = 3'd2,
      EXECUTA    = 3'd3,
      ERRO       = 3'd4
   } estado_t;
endpackage

// File: rtl/carregador_programa_if.sv
// rtl/carregador_programa_if.sv - byte stream and instruction fetch signals of the loader
interface carregador_programa_if;
   import carregador_programa_pkg::*;

   logic [LARGURA-1:0]  ByteEntrada;
   logic                ByteValido;
   logic                ByteAceito;
   logic                Recarregar;
   logic [ENDERECO-1:0] PC;
   logic [LARGURA-1:0]  InstrucaoLida;
   logic                ResetProcessador;
   logic                Carregado;
   logic                Erro;

   modport slave (
      input  ByteEntrada, ByteValido, Recarregar, PC,
      output ByteAceito, InstrucaoLida, ResetProcessador, Carregado, Erro
   );

   modport master (
      output ByteEntrada, ByteValido, Recarregar, PC,
      input  ByteAceito, InstrucaoLida, ResetProcessador, Carregado, Erro
   );
endinterface

// File: rtl/carregador_programa_memoria_instrucao.sv
// rtl/carregador_programa_memoria_instrucao.sv - 256x8 program store, sync write, async read
module memoria_instrucao
   import carregador_programa_pkg::*;
(
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [ENDERECO-1:0] waddr_i,
   input  logic [LARGURA-1:0]  wdata_i,
   input  logic [ENDERECO-1:0] raddr_i,
   output logic [LARGURA-1:0]  rdata_o
);
   // No reset: contents deliberately survive Reset and Recarregar.
   logic [LARGURA-1:0] mem_q [MEM_PROFUNDIDADE];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/carregador_programa.sv
// rtl/carregador_programa.sv - loads a length-prefixed, XOR-checked program then releases the processor
module carregador_programa
   import carregador_programa_pkg::*;
(
   input  logic                 Clock,
   input  logic                 Reset,
   carregador_programa_if.slave bus
);
   estado_t             estado_q, estado_d;
   logic [ENDERECO-1:0] contador_q, contador_d;
   logic [ENDERECO:0]   n_q, n_d;
   logic [LARGURA-1:0]  checksum_q, checksum_d;
   logic                escreve;
   logic                aceita;
   logic                transfere;
   logic [LARGURA-1:0]  dado_mem;

   assign transfere = bus.ByteValido && aceita;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado_q   <= ESPERA_TAM;
         contador_q <= '0;
         n_q        <= '0;
         checksum_q <= '0;
      end else begin
         estado_q   <= estado_d;
         contador_q <= contador_d;
         n_q        <= n_d;
         checksum_q <= checksum_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      contador_d = contador_q;
      n_d        = n_q;
      checksum_d = checksum_q;
      escreve    = 1'b0;
      if (bus.Recarregar) begin
         estado_d = ESPERA_TAM;
      end else if (transfere) begin
         case (estado_q)
            ESPERA_TAM: begin
               // A length byte of zero encodes a full 256-byte program.
               n_d        = (bus.ByteEntrada == '0) ? 9'd256 : {1'b0, bus.ByteEntrada};
               contador_d = '0;
               checksum_d = '0;
               estado_d   = CARGA;
            end
            CARGA: begin
               escreve    = 1'b1;
               checksum_d = checksum_q ^ bus.ByteEntrada;
               contador_d = contador_q + 8'd1;
               if (({1'b0, contador_q} + 9'd1) == n_q) begin
                  estado_d = CHECK;
               end
            end
            CHECK: begin
               estado_d = (bus.ByteEntrada == checksum_q) ? EXECUTA : ERRO;
            end
            default: estado_d = estado_q;
         endcase
      end
   end

   always_comb begin
      aceita               = 1'b0;
      bus.ByteAceito       = 1'b0;
      bus.ResetProcessador = (estado_q != EXECUTA);
      bus.Carregado        = (estado_q == EXECUTA);
      bus.Erro             = (estado_q == ERRO);
      bus.InstrucaoLida    = '0;
      if ((estado_q == ESPERA_TAM) || (estado_q == CARGA) || (estado_q == CHECK)) begin
         aceita = !bus.Recarregar;
      end
      bus.ByteAceito = aceita;
      // Gate by N so stale bytes from an earlier, longer load never leak out.
      if ((estado_q == EXECUTA) && ({1'b0, bus.PC} < n_q)) begin
         bus.InstrucaoLida = dado_mem;
      end
   end

   memoria_instrucao u_memoria (
      .clk_i   (Clock),
      .we_i    (escreve && !Reset),
      .waddr_i (contador_q),
      .wdata_i (bus.ByteEntrada),
      .raddr_i (bus.PC),
      .rdata_o (dado_mem)
   );
endmodule

// File: tb/tb_carregador_programa.sv
// tb/tb_carregador_programa.sv - directed self-checking bench for carregador_programa
module tb_carregador_programa;
   import carregador_programa_pkg::*;

   logic Clock;
   logic Reset;
   int   n_assert;
   int   n_fail;

   carregador_programa_if bus ();

   carregador_programa dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; the byte transfers on the following rising edge.
   task automatic send(input logic [7:0] b);
      bus.ByteEntrada = b;
      bus.ByteValido  = 1'b1;
      @(negedge Clock);
      bus.ByteValido  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic pulse_recarregar();
      bus.Recarregar = 1'b1;
      @(negedge Clock);
      bus.Recarregar = 1'b0;
   endtask

   initial begin
      n_assert        = 0;
      n_fail          = 0;
      Reset           = 1'b1;
      bus.ByteEntrada = 8'h00;
      bus.ByteValido  = 1'b0;
      bus.Recarregar  = 1'b0;
      bus.PC          = 8'h00;

      idle(2);
      chk("rst_resetproc", bus.ResetProcessador, 1'b1);
      chk("rst_carregado", bus.Carregado, 1'b0);
      chk("rst_erro", bus.Erro, 1'b0);
      chk("rst_instr", bus.InstrucaoLida, 8'h00);
      Reset = 1'b0;
      #1;
      chk("rst_aceito", bus.ByteAceito, 1'b1);
      chk("rst_estado", dut.estado_q, ESPERA_TAM);
      @(negedge Clock);

      // Nominal load
      send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD0);
      chk("nom_carregado", bus.Carregado, 1'b1);
      chk("nom_resetproc", bus.ResetProcessador, 1'b0);
      chk("nom_aceito", bus.ByteAceito, 1'b0);
      bus.PC = 8'h00; #1; chk("nom_pc0", bus.InstrucaoLida, 8'hA1);
      bus.PC = 8'h01; #1; chk("nom_pc1", bus.InstrucaoLida, 8'hB2);
      bus.PC = 8'h02; #1; chk("nom_pc2", bus.InstrucaoLida, 8'hC3);
      bus.PC = 8'h03; #1; chk("nom_pc3", bus.InstrucaoLida, 8'h00);
      @(negedge Clock);
      pulse_recarregar();
      chk("nom_reload_estado", dut.estado_q, ESPERA_TAM);
      chk("nom_reload_instr_gated", bus.InstrucaoLida, 8'h00);

      // Bad checksum
      send(8'h02); send(8'h11); send(8'h22); send(8'h00);
      chk("bad_erro", bus.Erro, 1'b1);
      chk("bad_resetproc", bus.ResetProcessador, 1'b1);
      chk("bad_aceito", bus.ByteAceito, 1'b0);
      chk("bad_carregado", bus.Carregado, 1'b0);
      send(8'h05);
      chk("bad_sticky", bus.Erro, 1'b1);
      pulse_recarregar();
      chk("bad_recover_erro", bus.Erro, 1'b0);
      chk("bad_recover_estado", dut.estado_q, ESPERA_TAM);

      // Abort mid-load; the byte offered alongside Recarregar is refused
      send(8'h04); send(8'h01); send(8'h02);
      bus.ByteEntrada = 8'h03;
      bus.ByteValido  = 1'b1;
      bus.Recarregar  = 1'b1;
      #1;
      chk("abort_aceito", bus.ByteAceito, 1'b0);
      @(negedge Clock);
      bus.ByteValido = 1'b0;
      bus.Recarregar = 1'b0;
      #1;
      chk("abort_estado", dut.estado_q, ESPERA_TAM);
      chk("abort_aceito_after", bus.ByteAceito, 1'b1);
      @(negedge Clock);
      send(8'h01); send(8'h5A); send(8'h5A);
      chk("abort_carregado", bus.Carregado, 1'b1);
      bus.PC = 8'h00; #1; chk("abort_pc0", bus.InstrucaoLida, 8'h5A);
      bus.PC = 8'h01; #1; chk("abort_pc1_stale", bus.InstrucaoLida, 8'h00);
      @(negedge Clock);
      pulse_recarregar();

      // Full-length load: XOR of 0..255 is zero
      send(8'h00);
      for (int i = 0; i < 256; i++) send(8'(i));
      chk("full_counter_wrap", dut.contador_q, 8'h00);
      chk("full_estado_check", dut.estado_q, CHECK);
      send(8'h00);
      chk("full_carregado", bus.Carregado, 1'b1);
      bus.PC = 8'hFF; #1; chk("full_pcff", bus.InstrucaoLida, 8'hFF);
      bus.PC = 8'h80; #1; chk("full_pc80", bus.InstrucaoLida, 8'h80);
      bus.PC = 8'h00; #1; chk("full_pc00", bus.InstrucaoLida, 8'h00);
      @(negedge Clock);
      pulse_recarregar();

      // Reset during CARGA after 2 of 5 bytes
      send(8'h05); send(8'h77); send(8'h88);
      Reset = 1'b1;
      bus.ByteEntrada = 8'h99;
      bus.ByteValido  = 1'b1;
      @(negedge Clock);
      bus.ByteValido = 1'b0;
      chk("rstmid_estado", dut.estado_q, ESPERA_TAM);
      chk("rstmid_n", dut.n_q, 9'd0);
      chk("rstmid_carregado", bus.Carregado, 1'b0);
      chk("rstmid_instr", bus.InstrucaoLida, 8'h00);
      Reset = 1'b0;
      #1;
      chk("rstmid_aceito", bus.ByteAceito, 1'b1);
      @(negedge Clock);

      // Nominal load with idle gaps, then bytes offered in EXECUTA
      send(8'h03); idle(3);
      send(8'hA1); idle(1);
      send(8'hB2); idle(5);
      chk("gap_estado_carga", dut.estado_q, CARGA);
      send(8'hC3); idle(2);
      send(8'hD0);
      chk("gap_carregado", bus.Carregado, 1'b1);
      send(8'h44); send(8'h55); idle(2);
      chk("gap_still_exec", bus.Carregado, 1'b1);
      bus.PC = 8'h00; #1; chk("gap_pc0", bus.InstrucaoLida, 8'hA1);
      bus.PC = 8'h01; #1; chk("gap_pc1", bus.InstrucaoLida, 8'hB2);
      bus.PC = 8'h02; #1; chk("gap_pc2", bus.InstrucaoLida, 8'hC3);
      bus.PC = 8'h03; #1; chk("gap_pc3", bus.InstrucaoLida, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
